demux_1x2_stream: RTL and testbench

DEMUX_1X2_STREAM -- requirements
Module: demux_1x2_stream

---
 rtl/demux_1x2_stream.sv | 94 +++++++++
 tb/tb_demux_1x2_stream.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_stream.sv
// 1-to-2 stream demultiplexer with an independent one-entry slot per output channel.
// Optional per-channel handshake counters are enabled by defining DEMUX_1X2_CNT_EN.
module demux_1x2_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_1X2_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            r_slot0, r_slot1;
  slot_t            w_slot0_nxt, w_slot1_nxt;
  logic [WIDTH-1:0] r_data0, r_data1;
  logic             w_in_hs, w_ld0, w_ld1, w_out0_hs, w_out1_hs;

  assign out0_valid = (r_slot0 == FULL);
  assign out1_valid = (r_slot1 == FULL);
  assign out0_data  = r_data0;
  assign out1_data  = r_data1;

  // A full slot still accepts when its consumer drains it in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (sel) in_ready = (r_slot1 == EMPTY) || out1_ready;
    else     in_ready = (r_slot0 == EMPTY) || out0_ready;
  end

  assign w_in_hs   = in_valid & in_ready;
  assign w_ld0     = w_in_hs & ~sel;
  assign w_ld1     = w_in_hs &  sel;
  assign w_out0_hs = out0_valid & out0_ready;
  assign w_out1_hs = out1_valid & out1_ready;

  always_comb begin
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (w_ld0)          w_slot0_nxt = FULL;
    else if (w_out0_hs) w_slot0_nxt = EMPTY;
    if (w_ld1)          w_slot1_nxt = FULL;
    else if (w_out1_hs) w_slot1_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= EMPTY;
      r_slot1 <= EMPTY;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
      if (w_ld0) r_data0 <= in_data;
      if (w_ld1) r_data1 <= in_data;
    end
  end

`ifdef DEMUX_1X2_CNT_EN
  logic [15:0] r_cnt0, r_cnt1;

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_out0_hs) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_out1_hs) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Directed, table-driven bench for demux_1x2_stream plus hand-written multi-cycle sequences.
// Counter checks are compiled in when DEMUX_1X2_CNT_EN is defined.
module tb_demux_1x2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, sel;
  logic [7:0] in_data;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic [7:0] out0_data, out1_data;
`ifdef DEMUX_1X2_CNT_EN
  logic        cnt_clr;
  logic [15:0] cnt0, cnt1;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  demux_1x2_stream #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_1X2_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  typedef struct {
    logic       iv;
    logic       sl;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic       e_v1;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic v0, input logic v1,
                            input logic [7:0] d0, input logic [7:0] d1);
    check({tag, ".out0_valid"}, {31'd0, out0_valid}, {31'd0, v0});
    check({tag, ".out1_valid"}, {31'd0, out1_valid}, {31'd0, v1});
    check({tag, ".out0_data"},  {24'd0, out0_data},  {24'd0, d0});
    check({tag, ".out1_data"},  {24'd0, out1_data},  {24'd0, d1});
  endtask

  initial begin
    //          iv  sl  d      r0  r1  rdy v0  v1  d0     d1
    vecs[0]  = '{1, 0, 8'hA5, 1, 0, 1, 1, 0, 8'hA5, 8'h00};
    vecs[1]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 8'hA5, 8'h00};
    vecs[2]  = '{1, 1, 8'h11, 1, 0, 1, 0, 1, 8'hA5, 8'h11};
    vecs[3]  = '{1, 1, 8'h22, 1, 0, 0, 0, 1, 8'hA5, 8'h11};
    vecs[4]  = '{1, 1, 8'h22, 1, 0, 0, 0, 1, 8'hA5, 8'h11};
    vecs[5]  = '{1, 1, 8'h22, 1, 1, 1, 0, 1, 8'hA5, 8'h22};
    vecs[6]  = '{0, 1, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 8'h22};
    vecs[7]  = '{1, 0, 8'h30, 1, 0, 1, 1, 1, 8'h30, 8'h22};
    vecs[8]  = '{1, 0, 8'h31, 1, 0, 1, 1, 1, 8'h31, 8'h22};
    vecs[9]  = '{1, 0, 8'h32, 1, 0, 1, 1, 1, 8'h32, 8'h22};
    vecs[10] = '{0, 0, 8'h00, 0, 0, 0, 1, 1, 8'h32, 8'h22};
    vecs[11] = '{1, 0, 8'h40, 0, 0, 0, 1, 1, 8'h32, 8'h22};
    vecs[12] = '{1, 1, 8'h40, 0, 0, 0, 1, 1, 8'h32, 8'h22};
    vecs[13] = '{0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h32, 8'h22};

    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_data = 8'h00;
    out0_ready = 1'b0; out1_ready = 1'b0;
`ifdef DEMUX_1X2_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 8'h00, 8'h00);
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_1X2_CNT_EN
    check("reset.cnt0", {16'd0, cnt0}, 32'd0);
    check("reset.cnt1", {16'd0, cnt1}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 14; i++) begin
      in_valid = vecs[i].iv; sel = vecs[i].sl; in_data = vecs[i].d;
      out0_ready = vecs[i].r0; out1_ready = vecs[i].r1;
      #1;
      check($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_v0, vecs[i].e_v1, vecs[i].e_d0, vecs[i].e_d1);
    end

    // Continuous channel-0 stream: accepted and presented every cycle.
    out0_ready = 1'b1; out1_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      in_data = 8'h50 + 8'(i);
      #1;
      check($sformatf("stream%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("stream%0d.out0_valid", i), {31'd0, out0_valid}, 32'd1);
      check($sformatf("stream%0d.out0_data", i), {24'd0, out0_data}, {24'd0, 8'h50 + 8'(i)});
    end

    // Fill both slots with stalled consumers, then reset mid-cycle.
    out0_ready = 1'b0; sel = 1'b1; in_data = 8'h62;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_outs("fill", 1'b1, 1'b1, 8'h55, 8'h62);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;
    sel = 1'b1;
    #1;
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = 8'h77; out1_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_outs("post_rst", 1'b0, 1'b1, 8'h00, 8'h77);
    @(posedge clk); #1;
    check("post_rst.drain", {31'd0, out1_valid}, 32'd0);

`ifdef DEMUX_1X2_CNT_EN
    check("cnt.cnt1_after", {16'd0, cnt1}, 32'd1);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; in_valid = 1'b1; in_data = 8'h01; out0_ready = 1'b1;
    @(posedge clk); #1;
    // First load only; the 65537 output handshakes follow.
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0; out0_ready = 1'b0;
    check("cnt.wrap_cnt0", {16'd0, cnt0}, 32'd1);
    check("cnt.wrap_cnt1", {16'd0, cnt1}, 32'd0);
    out0_ready = 1'b1; cnt_clr = 1'b1;
    check("cnt.clr_hs_valid", {31'd0, out0_valid}, 32'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b0; out0_ready = 1'b0;
    check("cnt.clr_priority", {16'd0, cnt0}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
